// File: rtl/sprite_ram_arbiter_if.sv
// CPU-side bus of the sprite RAM arbiter: request/ready handshake plus read-data strobe.
interface sprite_ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rdata, cpu_rvalid
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rdata, cpu_rvalid
  );
endinterface

// File: rtl/sprite_ram_arbiter.sv
// Single-port sprite attribute RAM shared between sprite_fsm (never stalled) and the CPU
// (posted one-entry write buffer, blocking reads).
//
// state   | meaning
// IDLE    | no CPU read outstanding; CPU reads/writes may be accepted
// RD_WAIT | CPU read issued to RAM, waiting for its tag to emerge
module sprite_ram_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vblank,
  input  logic               spr_rd_en,
  input  logic [ADDR_W-1:0]  spr_addr,
  output logic [DATA_W-1:0]  spr_dout,
  sprite_ram_arbiter_if.slave cpu,
  output logic               ram_en,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               spr_in_active
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t            state;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [RD_LAT-1:0] spr_tag;
  logic [RD_LAT-1:0] cpu_tag;
  logic [DATA_W-1:0] rdata_q;

  logic drain;
  logic wr_accept;
  logic rd_accept;
  logic spr_ret;
  logic cpu_ret;

  // Everything combinational is forced quiet while rst is high so in-flight reads vanish.
  always_comb begin
    drain     = !rst && wb_valid && !spr_rd_en;
    wr_accept = !rst && (state == IDLE) && cpu.cpu_req && cpu.cpu_we && !wb_valid;
    rd_accept = !rst && (state == IDLE) && cpu.cpu_req && !cpu.cpu_we && !wb_valid && !spr_rd_en;
    spr_ret   = !rst && spr_tag[RD_LAT-1];
    cpu_ret   = !rst && cpu_tag[RD_LAT-1];

    cpu.cpu_ready  = wr_accept || rd_accept;
    cpu.cpu_rvalid = cpu_ret;
    cpu.cpu_rdata  = rst ? '0 : (cpu_ret ? ram_rdata : rdata_q);
    spr_dout       = spr_ret ? ram_rdata : '0;

    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!rst && spr_rd_en) begin
      ram_en   = 1'b1;
      ram_addr = spr_addr;
    end else if (drain) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = wb_addr;
      ram_wdata = wb_data;
    end else if (rd_accept) begin
      ram_en   = 1'b1;
      ram_addr = cpu.cpu_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wb_valid      <= 1'b0;
      wb_addr       <= '0;
      wb_data       <= '0;
      spr_tag       <= '0;
      cpu_tag       <= '0;
      rdata_q       <= '0;
      stall_cnt     <= '0;
      spr_in_active <= 1'b0;
    end else begin
      if (drain) begin
        wb_valid <= 1'b0;
      end else if (wr_accept) begin
        wb_valid <= 1'b1;
        wb_addr  <= cpu.cpu_addr;
        wb_data  <= cpu.cpu_wdata;
      end

      spr_tag[0] <= spr_rd_en;
      cpu_tag[0] <= rd_accept;
      for (int i = 1; i < RD_LAT; i++) begin
        spr_tag[i] <= spr_tag[i-1];
        cpu_tag[i] <= cpu_tag[i-1];
      end

      case (state)
        IDLE:    if (rd_accept) state <= RD_WAIT;
        RD_WAIT: if (cpu_ret)   state <= IDLE;
        default: state <= IDLE;
      endcase

      if (cpu_ret) rdata_q <= ram_rdata;

      if (cpu.cpu_req && !cpu.cpu_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;

      if (spr_rd_en && !vblank) spr_in_active <= 1'b1;
    end
  end

endmodule
